// File: rtl/eth_desc_ram_axi_resp.sv
// AXI4 responder backing the Ethernet descriptor ring with flop storage; read and write FSMs run concurrently.
// ETH_DESC_RESP_RANGE_CHK_EN enables out-of-range detection (SLVERR, beats dropped/zeroed, no index wrap).
module eth_desc_ram_axi_resp #(
   parameter int AXI_DATA_WIDTH = 256,
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int DEPTH          = 32
) (
   input  logic                        clk_sys,
   input  logic                        rst_n_sys,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_axibus_awaddr,
   input  logic [7:0]                  s_axibus_awlen,
   input  logic                        s_axibus_awvalid,
   output logic                        s_axibus_awready,
   input  logic [AXI_DATA_WIDTH-1:0]   s_axibus_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] s_axibus_wstrb,
   input  logic                        s_axibus_wlast,
   input  logic                        s_axibus_wvalid,
   output logic                        s_axibus_wready,
   output logic [1:0]                  s_axibus_bresp,
   output logic                        s_axibus_bvalid,
   input  logic                        s_axibus_bready,
   input  logic [AXI_ADDR_WIDTH-1:0]   s_axibus_araddr,
   input  logic [7:0]                  s_axibus_arlen,
   input  logic                        s_axibus_arvalid,
   output logic                        s_axibus_arready,
   output logic [AXI_DATA_WIDTH-1:0]   s_axibus_rdata,
   output logic [1:0]                  s_axibus_rresp,
   output logic                        s_axibus_rlast,
   output logic                        s_axibus_rvalid,
   input  logic                        s_axibus_rready,
   output logic [15:0]                 err_cnt
);
   localparam int SW = AXI_DATA_WIDTH / 8;
   localparam int OW = $clog2(SW);
   localparam int IW = $clog2(DEPTH);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef ETH_DESC_RESP_RANGE_CHK_EN
   localparam logic RANGE_CHK = 1'b1;
`else
   localparam logic RANGE_CHK = 1'b0;
`endif

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   w_state_e                  w_state_q, w_state_d;
   logic [IW-1:0]             w_idx_q, w_idx_d;
   logic [7:0]                w_cnt_q, w_cnt_d;
   logic                      w_oor_q, w_oor_d;
   logic                      w_err_q, w_err_d;
   r_state_e                  r_state_q, r_state_d;
   logic [IW-1:0]             r_idx_q, r_idx_d;
   logic [7:0]                r_cnt_q, r_cnt_d;
   logic                      r_oor_q, r_oor_d;
   logic                      r_err_q, r_err_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [15:0]               err_cnt_q, err_cnt_d;
   logic [AXI_DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AXI_DATA_WIDTH-1:0] mem_d [DEPTH];

   logic          aw_hi_nz, ar_hi_nz, w_last_cnt, b_err_fire, r_err_fire, r_load, r_ld_oor;
   logic [IW-1:0] r_ld_idx;
   logic [16:0]   err_sum;
   logic          unused_ok;

   // Any address bit above the word-index field marks the whole burst out of range.
   assign aw_hi_nz  = RANGE_CHK & (|s_axibus_awaddr[AXI_ADDR_WIDTH-1:OW+IW]);
   assign ar_hi_nz  = RANGE_CHK & (|s_axibus_araddr[AXI_ADDR_WIDTH-1:OW+IW]);
   assign unused_ok = ^{s_axibus_awaddr[OW-1:0], s_axibus_araddr[OW-1:0]};

   always_comb begin
      w_state_d        = w_state_q;
      w_idx_d          = w_idx_q;
      w_cnt_d          = w_cnt_q;
      w_oor_d          = w_oor_q;
      w_err_d          = w_err_q;
      mem_d            = mem_q;
      w_last_cnt       = 1'b0;
      b_err_fire       = 1'b0;
      s_axibus_awready = 1'b0;
      s_axibus_wready  = 1'b0;
      s_axibus_bvalid  = 1'b0;
      s_axibus_bresp   = RESP_OKAY;
      case (w_state_q)
         W_IDLE: begin
            s_axibus_awready = 1'b1;
            if (s_axibus_awvalid) begin
               w_idx_d   = s_axibus_awaddr[OW +: IW];
               w_cnt_d   = s_axibus_awlen;
               w_oor_d   = aw_hi_nz;
               w_err_d   = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            s_axibus_wready = 1'b1;
            if (s_axibus_wvalid) begin
               if (!w_oor_q) begin
                  for (int b = 0; b < SW; b++) begin
                     if (s_axibus_wstrb[b]) mem_d[w_idx_q][b*8 +: 8] = s_axibus_wdata[b*8 +: 8];
                  end
               end
               w_last_cnt = (w_cnt_q == 8'd0);
               w_err_d    = w_err_q | w_oor_q | (s_axibus_wlast != w_last_cnt);
               if (s_axibus_wlast || w_last_cnt) begin
                  w_state_d = W_RESP;
               end else begin
                  // Stepping past the last word poisons the rest of the burst instead of wrapping.
                  w_cnt_d = w_cnt_q - 8'd1;
                  w_idx_d = w_idx_q + 1'b1;
                  w_oor_d = w_oor_q | (RANGE_CHK & (&w_idx_q));
               end
            end
         end
         W_RESP: begin
            s_axibus_bvalid = 1'b1;
            s_axibus_bresp  = w_err_q ? RESP_SLVERR : RESP_OKAY;
            if (s_axibus_bready) begin
               b_err_fire = w_err_q;
               w_state_d  = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d        = r_state_q;
      r_idx_d          = r_idx_q;
      r_cnt_d          = r_cnt_q;
      r_oor_d          = r_oor_q;
      r_err_d          = r_err_q;
      rdata_d          = rdata_q;
      r_ld_idx         = r_idx_q;
      r_ld_oor         = r_oor_q;
      r_load           = 1'b0;
      r_err_fire       = 1'b0;
      s_axibus_arready = 1'b0;
      s_axibus_rvalid  = 1'b0;
      s_axibus_rlast   = 1'b0;
      s_axibus_rresp   = RESP_OKAY;
      case (r_state_q)
         R_IDLE: begin
            s_axibus_arready = 1'b1;
            if (s_axibus_arvalid) begin
               r_ld_idx  = s_axibus_araddr[OW +: IW];
               r_ld_oor  = ar_hi_nz;
               r_cnt_d   = s_axibus_arlen;
               r_err_d   = 1'b0;
               r_load    = 1'b1;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            s_axibus_rvalid = 1'b1;
            s_axibus_rlast  = (r_cnt_q == 8'd0);
            s_axibus_rresp  = r_oor_q ? RESP_SLVERR : RESP_OKAY;
            if (s_axibus_rready) begin
               if (r_cnt_q == 8'd0) begin
                  r_err_fire = r_err_q | r_oor_q;
                  r_state_d  = R_IDLE;
               end else begin
                  r_ld_idx = r_idx_q + 1'b1;
                  r_ld_oor = r_oor_q | (RANGE_CHK & (&r_idx_q));
                  r_cnt_d  = r_cnt_q - 8'd1;
                  r_err_d  = r_err_q | r_oor_q;
                  r_load   = 1'b1;
               end
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      // Loads sample the pre-write array, so a same-cycle write shows up on the following beat.
      if (r_load) begin
         r_idx_d = r_ld_idx;
         r_oor_d = r_ld_oor;
         rdata_d = r_ld_oor ? '0 : mem_q[r_ld_idx];
      end
   end

   always_comb begin
      err_sum   = {1'b0, err_cnt_q} + 17'(b_err_fire) + 17'(r_err_fire);
      err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end

   assign s_axibus_rdata = rdata_q;
   assign err_cnt        = err_cnt_q;

   always_ff @(posedge clk_sys or negedge rst_n_sys) begin
      if (!rst_n_sys) begin
         w_state_q <= W_IDLE;
         w_idx_q   <= '0;
         w_cnt_q   <= '0;
         w_oor_q   <= 1'b0;
         w_err_q   <= 1'b0;
         r_state_q <= R_IDLE;
         r_idx_q   <= '0;
         r_cnt_q   <= '0;
         r_oor_q   <= 1'b0;
         r_err_q   <= 1'b0;
         rdata_q   <= '0;
         err_cnt_q <= '0;
      end else begin
         w_state_q <= w_state_d;
         w_idx_q   <= w_idx_d;
         w_cnt_q   <= w_cnt_d;
         w_oor_q   <= w_oor_d;
         w_err_q   <= w_err_d;
         r_state_q <= r_state_d;
         r_idx_q   <= r_idx_d;
         r_cnt_q   <= r_cnt_d;
         r_oor_q   <= r_oor_d;
         r_err_q   <= r_err_d;
         rdata_q   <= rdata_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   always_ff @(posedge clk_sys) begin
      mem_q <= mem_d;
   end
endmodule

// File: tb/tb_eth_desc_ram_axi_resp.sv
// Bench for eth_desc_ram_axi_resp: vector table, directed corner sequences, randomized traffic vs. a word-array model.
module tb_eth_desc_ram_axi_resp;
   localparam int DW = 256, AW = 64, DEPTH = 32, SW = DW / 8, TMO = 400;
   localparam int OB = $clog2(SW), IB = $clog2(DEPTH);
`ifdef ETH_DESC_RESP_RANGE_CHK_EN
   localparam bit RCHK = 1'b1;
`else
   localparam bit RCHK = 1'b0;
`endif
   localparam logic [1:0] OORR = RCHK ? 2'b10 : 2'b00;

   logic clk_sys = 1'b0, rst_n_sys = 1'b0;
   logic [AW-1:0] awaddr, araddr;
   logic [7:0]    awlen, arlen;
   logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic          arvalid, arready, rlast, rvalid, rready;
   logic [DW-1:0] wdata, rdata;
   logic [SW-1:0] wstrb;
   logic [1:0]    bresp, rresp;
   logic [15:0]   err_cnt;

   always #5 clk_sys = ~clk_sys;

   eth_desc_ram_axi_resp dut (
      .clk_sys(clk_sys), .rst_n_sys(rst_n_sys),
      .s_axibus_awaddr(awaddr), .s_axibus_awlen(awlen), .s_axibus_awvalid(awvalid), .s_axibus_awready(awready),
      .s_axibus_wdata(wdata), .s_axibus_wstrb(wstrb), .s_axibus_wlast(wlast), .s_axibus_wvalid(wvalid),
      .s_axibus_wready(wready), .s_axibus_bresp(bresp), .s_axibus_bvalid(bvalid), .s_axibus_bready(bready),
      .s_axibus_araddr(araddr), .s_axibus_arlen(arlen), .s_axibus_arvalid(arvalid), .s_axibus_arready(arready),
      .s_axibus_rdata(rdata), .s_axibus_rresp(rresp), .s_axibus_rlast(rlast), .s_axibus_rvalid(rvalid),
      .s_axibus_rready(rready), .err_cnt(err_cnt)
   );

   int n_vec = 0, n_err = 0;
   int mdl_errs = 0;
   logic [DW-1:0] mdl_mem [DEPTH];
   logic [DW-1:0] wd [256];
   logic [SW-1:0] ws [256];
   logic [DW-1:0] rd_dat [$];
   logic [1:0]    rd_rsp [$];
   logic          rd_lst [$];

   typedef struct {
      bit          is_wr;
      logic [AW-1:0] addr;
      int          len;
      int          wl;
      int          dmode;
      bit          pstrb;
      logic [1:0]  exp_resp;
   } vec_t;
   vec_t tbl [13];

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tmo(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL timeout %s: no handshake within %0d cycles", nm, TMO);
   endtask

   function automatic bit beat_oor(input logic [AW-1:0] addr, input int beat);
      return RCHK && (((addr >> (OB + IB)) != '0) || (int'(addr[OB +: IB]) + beat >= DEPTH));
   endfunction

   task automatic fill_wdata(input logic [AW-1:0] addr, input int nb, input int dmode, input bit pstrb);
      for (int i = 0; i < nb; i++) begin
         case (dmode)
            0:       wd[i] = DW'(int'(addr[OB +: IB]) + i);
            1:       wd[i] = {32{8'hA5}};
            default: for (int j = 0; j < DW / 32; j++) wd[i][j*32 +: 32] = $urandom();
         endcase
         ws[i] = pstrb ? SW'($urandom()) : '1;
      end
   endtask

   // Model: beats are consecutive word indices; bad beats are skipped, anything bad makes the burst SLVERR.
   task automatic mdl_write(input logic [AW-1:0] addr, input int len, input int wl, output logic [1:0] resp);
      int nb;
      bit err;
      nb  = ((wl < len) ? wl : len) + 1;
      err = (wl != len);
      for (int i = 0; i < nb; i++) begin
         if (beat_oor(addr, i)) err = 1'b1;
         else begin
            for (int b = 0; b < SW; b++)
               if (ws[i][b]) mdl_mem[(int'(addr[OB +: IB]) + i) % DEPTH][b*8 +: 8] = wd[i][b*8 +: 8];
         end
      end
      resp = err ? 2'b10 : 2'b00;
      if (err) mdl_errs++;
   endtask

   task automatic bus_write(input logic [AW-1:0] addr, input int len, input int wl, input bit rnd,
                            output logic [1:0] resp, output int blat);
      int n, nb;
      nb = ((wl < len) ? wl : len) + 1;
      resp = 2'bxx;
      blat = -1;
      awaddr = addr; awlen = 8'(len); awvalid = 1'b1;
      n = 0;
      while (!awready && n < TMO) begin @(negedge clk_sys); n++; end
      if (n >= TMO) tmo("aw");
      @(negedge clk_sys);
      awvalid = 1'b0;
      for (int i = 0; i < nb; i++) begin
         if (rnd && $urandom_range(0, 3) == 0) begin wvalid = 1'b0; @(negedge clk_sys); end
         wdata = wd[i]; wstrb = ws[i]; wlast = (i == wl); wvalid = 1'b1;
         n = 0;
         while (!wready && n < TMO) begin @(negedge clk_sys); n++; end
         if (n >= TMO) tmo("w");
         @(negedge clk_sys);
      end
      wvalid = 1'b0; wlast = 1'b0;
      n = 0;
      while (!bvalid && n < TMO) begin @(negedge clk_sys); n++; end
      if (n >= TMO) tmo("b");
      blat = n;
      resp = bresp;
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk_sys);
      bready = 1'b1;
      @(negedge clk_sys);
      bready = 1'b0;
   endtask

   task automatic bus_read(input logic [AW-1:0] addr, input int len, input bit rnd, output int first_lat);
      int n;
      bit done;
      rd_dat.delete(); rd_rsp.delete(); rd_lst.delete();
      first_lat = -1;
      araddr = addr; arlen = 8'(len); arvalid = 1'b1;
      n = 0;
      while (!arready && n < TMO) begin @(negedge clk_sys); n++; end
      if (n >= TMO) tmo("ar");
      @(negedge clk_sys);
      arvalid = 1'b0;
      n = 0; done = 1'b0;
      while (!done && n < TMO) begin
         rready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (rvalid && first_lat < 0) first_lat = n;
         if (rvalid && rready) begin
            rd_dat.push_back(rdata); rd_rsp.push_back(rresp); rd_lst.push_back(rlast);
            done = rlast;
         end
         @(negedge clk_sys);
         n++;
      end
      rready = 1'b0;
      if (!done) tmo("r");
   endtask

   task automatic check_read(input string nm, input logic [AW-1:0] addr, input int len);
      bit err, oor;
      logic [DW-1:0] e;
      err = 1'b0;
      chk({nm, ".beats"}, DW'(rd_dat.size()), DW'(len + 1));
      for (int i = 0; i <= len && i < rd_dat.size(); i++) begin
         oor = beat_oor(addr, i);
         e   = oor ? '0 : mdl_mem[(int'(addr[OB +: IB]) + i) % DEPTH];
         chk($sformatf("%s.b%0d.data", nm, i), rd_dat[i], e);
         chk($sformatf("%s.b%0d.resp", nm, i), DW'(rd_rsp[i]), DW'(oor ? 2'b10 : 2'b00));
         chk($sformatf("%s.b%0d.last", nm, i), DW'(rd_lst[i]), DW'(i == len));
         err |= oor;
      end
      if (err) mdl_errs++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] er, br;
      int lat;
      logic [DW-1:0] oldv, newv;
      logic [AW-1:0] addr;
      int len, wl, idx;

      awaddr = '0; awlen = '0; awvalid = 0; wdata = '0; wstrb = '0; wlast = 0; wvalid = 0; bready = 0;
      araddr = '0; arlen = '0; arvalid = 0; rready = 0;

      tbl[0]  = '{1'b1, 64'h0,           31, 31, 0, 1'b0, 2'b00};
      tbl[1]  = '{1'b0, 64'h0,            3,  0, 0, 1'b0, 2'b00};
      tbl[2]  = '{1'b1, 64'h40,           0,  0, 1, 1'b0, 2'b00};
      tbl[3]  = '{1'b0, 64'h40,           0,  0, 0, 1'b0, 2'b00};
      tbl[4]  = '{1'b0, 64'h3E0,          1,  0, 0, 1'b0, OORR};
      tbl[5]  = '{1'b1, 64'h100,          3,  1, 2, 1'b0, 2'b10};
      tbl[6]  = '{1'b0, 64'h100,          3,  0, 0, 1'b0, 2'b00};
      tbl[7]  = '{1'b1, 64'h3E0,          1,  1, 2, 1'b0, OORR};
      tbl[8]  = '{1'b0, 64'h0,            0,  0, 0, 1'b0, 2'b00};
      tbl[9]  = '{1'b1, 64'h1_0000_0060,  0,  0, 2, 1'b1, OORR};
      tbl[10] = '{1'b0, 64'h1_0000_0060,  0,  0, 0, 1'b0, OORR};
      tbl[11] = '{1'b1, 64'h60,           1,  5, 2, 1'b1, 2'b10};
      tbl[12] = '{1'b0, 64'h60,           1,  0, 0, 1'b0, 2'b00};

      // Reset values
      repeat (3) @(negedge clk_sys);
      chk("rst.awready", DW'(awready), DW'(1));
      chk("rst.wready",  DW'(wready),  DW'(0));
      chk("rst.bvalid",  DW'(bvalid),  DW'(0));
      chk("rst.bresp",   DW'(bresp),   DW'(0));
      chk("rst.arready", DW'(arready), DW'(1));
      chk("rst.rvalid",  DW'(rvalid),  DW'(0));
      chk("rst.rlast",   DW'(rlast),   DW'(0));
      chk("rst.rresp",   DW'(rresp),   DW'(0));
      chk("rst.rdata",   rdata,        '0);
      chk("rst.err_cnt", DW'(err_cnt), DW'(0));
      rst_n_sys = 1'b1;
      @(negedge clk_sys);

      for (int t = 0; t < 13; t++) begin
         if (tbl[t].is_wr) begin
            fill_wdata(tbl[t].addr, tbl[t].len + 1, tbl[t].dmode, tbl[t].pstrb);
            bus_write(tbl[t].addr, tbl[t].len, tbl[t].wl, 1'b0, br, lat);
            mdl_write(tbl[t].addr, tbl[t].len, tbl[t].wl, er);
            chk($sformatf("tbl%0d.bresp", t), DW'(br), DW'(tbl[t].exp_resp));
            chk($sformatf("tbl%0d.b_latency", t), DW'(lat), DW'(0));
         end else begin
            bus_read(tbl[t].addr, tbl[t].len, 1'b0, lat);
            check_read($sformatf("tbl%0d", t), tbl[t].addr, tbl[t].len);
            chk($sformatf("tbl%0d.r_latency", t), DW'(lat), DW'(0));
            if (rd_rsp.size() > 0)
               chk($sformatf("tbl%0d.rresp_last", t), DW'(rd_rsp[rd_rsp.size()-1]), DW'(tbl[t].exp_resp));
         end
         chk($sformatf("tbl%0d.err_cnt", t), DW'(err_cnt), DW'(mdl_errs));
      end

      // Same word written and read in the same cycle: read sees the old value
      oldv = mdl_mem[5];
      newv = {8{32'hC0DE_0005}};
      awaddr = 64'hA0; awlen = 8'd0; awvalid = 1'b1;
      chk("same.awready", DW'(awready), DW'(1));
      @(negedge clk_sys);
      awvalid = 1'b0;
      chk("same.wready", DW'(wready), DW'(1));
      chk("same.awready_low", DW'(awready), DW'(0));
      wdata = newv; wstrb = '1; wlast = 1'b1; wvalid = 1'b1;
      araddr = 64'hA0; arlen = 8'd0; arvalid = 1'b1;
      chk("same.arready", DW'(arready), DW'(1));
      @(negedge clk_sys);
      wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
      chk("same.rvalid", DW'(rvalid), DW'(1));
      chk("same.rdata_old", rdata, oldv);
      chk("same.bvalid", DW'(bvalid), DW'(1));
      chk("same.arready_low", DW'(arready), DW'(0));
      rready = 1'b1; bready = 1'b1;
      @(negedge clk_sys);
      rready = 1'b0; bready = 1'b0;
      chk("same.arready_back", DW'(arready), DW'(1));
      chk("same.awready_back", DW'(awready), DW'(1));
      mdl_mem[5] = newv;
      bus_read(64'hA0, 0, 1'b0, lat);
      check_read("same.followup", 64'hA0, 0);

      // Reset in the middle of a read burst
      araddr = 64'h0; arlen = 8'd3; arvalid = 1'b1;
      @(negedge clk_sys);
      arvalid = 1'b0;
      chk("rstmid.rvalid_pre", DW'(rvalid), DW'(1));
      rready = 1'b1;
      @(negedge clk_sys);
      rready = 1'b0;
      rst_n_sys = 1'b0;
      #1;
      chk("rstmid.rvalid", DW'(rvalid), DW'(0));
      chk("rstmid.arready", DW'(arready), DW'(1));
      chk("rstmid.err_cnt", DW'(err_cnt), DW'(0));
      mdl_errs = 0;
      @(negedge clk_sys);
      rst_n_sys = 1'b1;
      @(negedge clk_sys);
      fill_wdata(64'h0, DEPTH, 0, 1'b0);
      bus_write(64'h0, DEPTH - 1, DEPTH - 1, 1'b0, br, lat);
      mdl_write(64'h0, DEPTH - 1, DEPTH - 1, er);
      chk("rstmid.reinit_bresp", DW'(br), DW'(0));
      bus_read(64'h40, 2, 1'b0, lat);
      chk("rstmid.ar_latency", DW'(lat), DW'(0));
      check_read("rstmid.read", 64'h40, 2);

      // Randomized traffic against the model
      for (int k = 0; k < 60; k++) begin
         idx  = $urandom_range(0, DEPTH - 1);
         addr = (AW'(idx) << OB) | AW'($urandom_range(0, SW - 1));
         if ($urandom_range(0, 7) == 0) addr[40] = 1'b1;
         len = $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 1) begin
            wl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 1) : len;
            fill_wdata(addr, len + 1, 2, $urandom_range(0, 1) == 1);
            bus_write(addr, len, wl, 1'b1, br, lat);
            mdl_write(addr, len, wl, er);
            chk($sformatf("rnd%0d.bresp", k), DW'(br), DW'(er));
         end else begin
            bus_read(addr, len, 1'b1, lat);
            check_read($sformatf("rnd%0d", k), addr, len);
         end
         chk($sformatf("rnd%0d.err_cnt", k), DW'(err_cnt), DW'(mdl_errs));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/eth_desc_ram_axi_resp.md
# eth_desc_ram_axi_resp

AXI4 responder that backs an Ethernet descriptor ring with on-chip flop storage. It is the target end of the descriptor traffic issued by the Ethernet DMA initiator: it serves AR/R descriptor-fetch bursts and AW/W/B descriptor write-backs. Read and write channels run concurrently against one shared array. Protocol errors and out-of-range accesses are counted.

## Interface
- AXI_DATA_WIDTH, 256: data bus width in bits; one beat is one storage word.
- AXI_ADDR_WIDTH, 64: address width.
- DEPTH, 32: number of storage words; must be a power of 2.
- clk_sys  in  1  system clock.
- rst_n_sys  in  1  reset, asynchronous, active-low.
- s_axibus_awaddr / awlen / awvalid  in  AXI_ADDR_WIDTH / 8 / 1  write address channel.
- s_axibus_awready  out  1  write address ready.
- s_axibus_wdata / wstrb / wlast / wvalid  in  AXI_DATA_WIDTH / AXI_DATA_WIDTH/8 / 1 / 1  write data channel.
- s_axibus_wready  out  1  write data ready.
- s_axibus_bresp / bvalid  out  2 / 1  write response.
- s_axibus_bready  in  1  write response ready.
- s_axibus_araddr / arlen / arvalid  in  AXI_ADDR_WIDTH / 8 / 1  read address channel.
- s_axibus_arready  out  1  read address ready.
- s_axibus_rdata / rresp / rlast / rvalid  out  AXI_DATA_WIDTH / 2 / 1 / 1  read data channel.
- s_axibus_rready  in  1  read data ready.
- err_cnt  out  16  saturating count of bursts answered with SLVERR.

## Operation
- Word index is addr[log2(AXI_DATA_WIDTH/8) +: log2(DEPTH)]. Byte-offset bits are ignored. All bursts are INCR; a burst of awlen/arlen+1 beats advances the index by 1 per beat.
- A beat is out of range when its index is DEPTH or greater, or when any address bit above the index field is nonzero.
- Write FSM has three states:
  - W_IDLE: awready=1. On AW handshake, latch the index and the beat count, then go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes bytes where wstrb is 1 into an in-range word; out-of-range beats are dropped. The burst ends on wlast or when the beat count is exhausted, whichever comes first. On end, go to W_RESP.
  - W_RESP: bvalid=1. bresp=2'b10 (SLVERR) if any beat was out of range or wlast did not coincide with the final counted beat; otherwise 2'b00. On bready, go to W_IDLE.
- Read FSM has two states:
  - R_IDLE: arready=1. On AR handshake, latch the index and count, then go to R_DATA.
  - R_DATA: rvalid=1. rdata holds the registered contents of the current word; out-of-range beats return all-zero data with rresp=2'b10, in-range beats return rresp=2'b00. rlast=1 on the final beat. On rready, the next word is loaded in the same cycle. After the final handshake, go to R_IDLE.
- Storage is not reset; contents are undefined after reset.
- err_cnt increments by 1 per burst that completes with SLVERR: on the B handshake for writes, on the rlast handshake for reads (a read counts once regardless of how many beats were bad). When a read and a write both complete with SLVERR in the same cycle, err_cnt increments by 2. err_cnt saturates at 16'hFFFF.

## Timing
- Reset values: awready=1, wready=0, bvalid=0, bresp=0, arready=1, rvalid=0, rlast=0, rresp=0, rdata=0, err_cnt=0.
- AW handshake to wready=1: 1 cycle. Final W beat to bvalid=1: 1 cycle. bvalid holds until bready.
- AR handshake to first rvalid: 1 cycle. Throughput is 1 beat/cycle while rready=1.
- arready/awready deassert the cycle after their handshake and reassert the cycle after the burst's final R or B handshake.
- Same-word read and write in one cycle: R returns the old data; the write is visible to the next beat.
- A burst that runs past DEPTH-1 has its wrapped beats treated as out of range; the index never wraps.
- Reset mid-burst aborts both FSMs to IDLE immediately; no response is issued for the aborted burst.

## Configuration
- ETH_DESC_RESP_RANGE_CHK_EN defined: out-of-range handling as above.
- ETH_DESC_RESP_RANGE_CHK_EN undefined: the upper address bits are ignored and the index wraps modulo DEPTH; every response is OKAY except wlast-mismatch SLVERR; err_cnt counts only wlast mismatches.

## Test plan
- Write addr 0x40, awlen 0, wstrb all ones, data 0xA5..; then read addr 0x40 -> rdata equal to the written data, rresp 0, rlast 1, err_cnt 0.
- Read addr 0x0, arlen 3 after loading words 0..3, rready held 1 -> four consecutive rvalid beats with data 0,1,2,3 and rlast on beat 4.
- Read addr 0x3E0 (index 31), arlen 1, range check on -> beat 1 returns word 31 with OKAY, beat 2 returns zero with SLVERR; err_cnt = 1.
- Write awlen 3 with wlast on beat 2 -> burst ends after beat 2, bresp 2'b10, err_cnt increments.
- Read and write of the same word in the same cycle -> rdata is the old value; a follow-up read returns the new value.
- Assert rst_n_sys low during R_DATA -> rvalid=0 and arready=1 immediately; a new AR is accepted normally.
